// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit masks and hex-to-segment pattern table
package seg_pkg;

    // Segment masks, active-high, bit6 = a .. bit0 = g.
    localparam logic [6:0] SEG_A    = 7'b100_0000;
    localparam logic [6:0] SEG_B    = 7'b010_0000;
    localparam logic [6:0] SEG_C    = 7'b001_0000;
    localparam logic [6:0] SEG_D    = 7'b000_1000;
    localparam logic [6:0] SEG_E    = 7'b000_0100;
    localparam logic [6:0] SEG_F    = 7'b000_0010;
    localparam logic [6:0] SEG_G    = 7'b000_0001;
    localparam logic [6:0] SEG_NONE = 7'b000_0000;

    // Hex digit glyphs 0-F (lower-case b and d so they differ from 8 and 0).
    localparam logic [6:0] HEX_SEG [16] = '{
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F,          // 0
        SEG_B | SEG_C,                                          // 1
        SEG_A | SEG_B | SEG_D | SEG_E | SEG_G,                  // 2
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_G,                  // 3
        SEG_B | SEG_C | SEG_F | SEG_G,                          // 4
        SEG_A | SEG_C | SEG_D | SEG_F | SEG_G,                  // 5
        SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,          // 6
        SEG_A | SEG_B | SEG_C,                                  // 7
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,  // 8
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G,          // 9
        SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G,          // A
        SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,                  // b
        SEG_A | SEG_D | SEG_E | SEG_F,                          // C
        SEG_B | SEG_C | SEG_D | SEG_E | SEG_G,                  // d
        SEG_A | SEG_D | SEG_E | SEG_F | SEG_G,                  // E
        SEG_A | SEG_E | SEG_F | SEG_G                           // F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to 7-segment decode
//   hex : 4-bit digit value
//   seg : active-high segments, bit6 = a .. bit0 = g
module seg_hex_decode (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    import seg_pkg::*;

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_pwm.sv
// rtl/seg_scan_pwm.sv - multiplexed 7-segment scanner with PWM dimming
//   clk, rst          : clock, asynchronous active-high reset
//   digits            : hex nibbles, digit i at [4i+3:4i]
//   dp_in, blank      : per-digit decimal point and force-off
//   lz_en             : leading-zero suppression enable
//   brightness        : duty level, all-ones = always lit, 0 = dark
//   seg, dp, an       : registered segment, decimal point and digit enables
//   frame_tick        : one-cycle pulse after each snapshot capture
module seg_scan_pwm #(
    parameter int NUM_DIG    = 8,
    parameter int SLOT_LOG2  = 17,
    parameter int PWM_BITS   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   digits,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic [NUM_DIG-1:0]     blank,
    input  logic                   lz_en,
    input  logic [PWM_BITS-1:0]    brightness,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NUM_DIG-1:0]     an,
    output logic                   frame_tick
);
    import seg_pkg::*;

    localparam int                IDX_W    = $clog2(NUM_DIG);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIG - 1);

    logic [SLOT_LOG2-1:0]  prescaler;
    logic [IDX_W-1:0]      idx;
    logic [4*NUM_DIG-1:0]  snap_digits;
    logic [NUM_DIG-1:0]    snap_dp;
    logic [NUM_DIG-1:0]    snap_blank;
    logic                  snap_lz;
    // Cleared by reset so the frame before the first capture stays dark.
    logic                  snap_valid;

    logic                  slot_end;
    logic                  capture;
    logic [PWM_BITS-1:0]   phase;
    logic                  lit;
    logic                  suppressed;
    logic                  show;
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_zero_run;
    logic                  zero_run;
    logic [6:0]            hex_seg;
    logic [NUM_DIG-1:0]    an_on;

    assign slot_end = &prescaler;
    assign capture  = slot_end && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            snap_valid  <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_tick <= capture;
            if (slot_end) begin
                // Explicit wrap so non-power-of-two digit counts skip unused indices.
                idx <= capture ? '0 : idx + 1'b1;
            end
            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_blank  <= blank;
                snap_lz     <= lz_en;
                snap_valid  <= 1'b1;
            end
        end
    end

    // Select the current digit and note whether it and all higher digits are zero.
    always_comb begin
        cur_digit    = 4'h0;
        cur_dp       = 1'b0;
        cur_blank    = 1'b0;
        cur_zero_run = 1'b0;
        zero_run     = 1'b1;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_digits[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_digit    = snap_digits[4*i +: 4];
                cur_dp       = snap_dp[i];
                cur_blank    = snap_blank[i];
                cur_zero_run = zero_run;
            end
        end
    end

    assign phase      = prescaler[SLOT_LOG2-1 -: PWM_BITS];
    assign lit        = (phase < brightness) || (&brightness);
    assign suppressed = snap_lz && (idx != '0) && cur_zero_run;
    assign show       = snap_valid && lit && !suppressed && !cur_blank;
    assign an_on      = show ? (NUM_DIG'(1) << idx) : '0;

    seg_hex_decode u_decode (
        .hex (cur_digit),
        .seg (hex_seg)
    );

    // Polarity is applied only here, at the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= {NUM_DIG{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_on ^ {NUM_DIG{ACTIVE_LOW}};
            seg <= (show ? hex_seg : SEG_NONE) ^ {7{ACTIVE_LOW}};
            dp  <= (show && cur_dp) ^ ACTIVE_LOW;
        end
    end

endmodule
